// File: rtl/sine_pwm_pkg.sv
// Shared types and elaboration-time helpers for the sine PWM DDS.
// sine_entry is evaluated only in constant context to fill the LUT.
package sine_pwm_pkg;

    localparam real TwoPi = 6.283185307179586;

    typedef enum logic [1:0] {
        SeqIdle,
        SeqAddr,
        SeqScale,
        SeqWrite
    } seq_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((longint'(1) << result) < longint'(value)) begin
            result++;
        end
        return result;
    endfunction

    function automatic int unsigned sine_entry(input int unsigned i, input int unsigned aw,
                                               input int unsigned dw);
        real full;
        real ang;
        full = real'((longint'(1) << dw) - 1);
        ang  = TwoPi * real'(i) / real'(longint'(1) << aw);
        return $rtoi($floor(full * (1.0 + $sin(ang)) / 2.0 + 0.5));
    endfunction

endpackage

// File: rtl/sine_lut.sv
// Full-cycle offset-binary sine ROM with one cycle of read latency.
module sine_lut
    import sine_pwm_pkg::*;
#(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 12
) (
    input  logic          clk,
    input  logic [AW-1:0] addr_i,
    output logic [DW-1:0] data_o
);

    logic [DW-1:0] rom [2**AW];
    logic [DW-1:0] data_d;
    logic [DW-1:0] data_q;

    for (genvar i = 0; i < 2**AW; i++) begin : g_rom
        localparam logic [DW-1:0] Entry = DW'(sine_entry(i, AW, DW));
        assign rom[i] = Entry;
    end

    always_comb begin
        data_d = rom[addr_i];
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign data_o = data_q;

endmodule

// File: rtl/sine_pwm_dds.sv
// Multi-channel sine-modulated PWM: per-period DDS accumulator, shared LUT
// sequenced once per period into shadow duties that go live at the next boundary.
module sine_pwm_dds
    import sine_pwm_pkg::*;
#(
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned PERIOD   = 1000,
    parameter int unsigned PHASE_W  = 24,
    parameter int unsigned LUT_AW   = 8,
    parameter int unsigned LUT_DW   = 12
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [PHASE_W-1:0]          tune_word,
    input  logic [CHANNELS*PHASE_W-1:0] phase_offset,
    input  logic                        sync,
    output logic [CHANNELS-1:0]         pwm_out,
    output logic                        period_tick
);

    localparam int unsigned CntW  = clog2(PERIOD);
    localparam int unsigned IdxW  = (CHANNELS > 1) ? clog2(CHANNELS) : 1;
    localparam int unsigned ProdW = LUT_DW + CntW;
    localparam logic [CntW-1:0] CntMax  = CntW'(PERIOD - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(CHANNELS - 1);

    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [PHASE_W-1:0] acc_q, acc_d;
    logic               sync_pending_q, sync_pending_d;
    logic [CntW-1:0]    duty_active_q [CHANNELS];
    logic [CntW-1:0]    duty_active_d [CHANNELS];
    logic [CntW-1:0]    duty_shadow_q [CHANNELS];
    logic [CntW-1:0]    duty_shadow_d [CHANNELS];
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic               tick_q, tick_d;

    seq_state_e         state_q, state_d;
    logic [IdxW-1:0]    issue_idx_q, issue_idx_d;
    logic               rd_vld_q, rd_vld_d;
    logic [IdxW-1:0]    rd_idx_q, rd_idx_d;
    logic               wr_vld_q, wr_vld_d;
    logic [IdxW-1:0]    wr_idx_q, wr_idx_d;
    logic [CntW-1:0]    wr_duty_q, wr_duty_d;

    logic               tick;
    logic [PHASE_W-1:0] offset_sel;
    logic [PHASE_W-1:0] phase_sum;
    logic [LUT_AW-1:0]  lut_addr;
    logic [LUT_DW-1:0]  lut_data;
    logic [ProdW-1:0]   prod;
    logic               unused_low_bits;

    assign tick = en && (cnt_q == CntMax);

    always_comb begin
        offset_sel = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (issue_idx_q == IdxW'(k)) begin
                offset_sel = phase_offset[k*PHASE_W +: PHASE_W];
            end
        end
    end

    assign phase_sum = acc_q + offset_sel;
    assign lut_addr  = phase_sum[PHASE_W-1 -: LUT_AW];

    sine_lut #(
        .AW (LUT_AW),
        .DW (LUT_DW)
    ) u_lut (
        .clk    (clk),
        .addr_i (lut_addr),
        .data_o (lut_data)
    );

    // duty = (lut * PERIOD) >> LUT_DW, so only the top CntW product bits matter.
    assign prod = ProdW'(lut_data) * ProdW'(PERIOD);
    assign unused_low_bits = ^{phase_sum[PHASE_W-LUT_AW-1:0], prod[LUT_DW-1:0]};

    always_comb begin
        cnt_d          = '0;
        acc_d          = acc_q;
        sync_pending_d = sync_pending_q | sync;
        duty_active_d  = duty_active_q;
        tick_d         = tick;
        if (en) begin
            cnt_d = tick ? '0 : cnt_q + CntW'(1);
        end
        if (tick) begin
            acc_d          = (sync_pending_q || sync) ? '0 : acc_q + tune_word;
            sync_pending_d = 1'b0;
            duty_active_d  = duty_shadow_q;
        end
        for (int k = 0; k < CHANNELS; k++) begin
            pwm_d[k] = en && (cnt_q < duty_active_q[k]);
        end
    end

    // Three-stage lookup pipeline: issue address, scale LUT sample, store shadow.
    always_comb begin
        state_d       = state_q;
        issue_idx_d   = issue_idx_q;
        rd_vld_d      = 1'b0;
        rd_idx_d      = issue_idx_q;
        wr_vld_d      = rd_vld_q;
        wr_idx_d      = rd_idx_q;
        wr_duty_d     = prod[LUT_DW +: CntW];
        duty_shadow_d = duty_shadow_q;
        if (wr_vld_q) begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (wr_idx_q == IdxW'(k)) begin
                    duty_shadow_d[k] = wr_duty_q;
                end
            end
        end
        if (!en) begin
            state_d     = SeqIdle;
            issue_idx_d = '0;
            wr_vld_d    = 1'b0;
        end else begin
            unique case (state_q)
                SeqIdle: begin
                    if (tick) begin
                        state_d     = SeqAddr;
                        issue_idx_d = '0;
                    end
                end
                SeqAddr: begin
                    rd_vld_d = 1'b1;
                    if (issue_idx_q == IdxLast) begin
                        state_d = SeqScale;
                    end else begin
                        issue_idx_d = issue_idx_q + IdxW'(1);
                    end
                end
                SeqScale: state_d = SeqWrite;
                SeqWrite: state_d = SeqIdle;
                default:  state_d = SeqIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q          <= '0;
            acc_q          <= '0;
            sync_pending_q <= 1'b0;
            duty_active_q  <= '{default: '0};
            duty_shadow_q  <= '{default: '0};
            pwm_q          <= '0;
            tick_q         <= 1'b0;
            state_q        <= SeqIdle;
            issue_idx_q    <= '0;
            rd_vld_q       <= 1'b0;
            rd_idx_q       <= '0;
            wr_vld_q       <= 1'b0;
            wr_idx_q       <= '0;
            wr_duty_q      <= '0;
        end else begin
            cnt_q          <= cnt_d;
            acc_q          <= acc_d;
            sync_pending_q <= sync_pending_d;
            duty_active_q  <= duty_active_d;
            duty_shadow_q  <= duty_shadow_d;
            pwm_q          <= pwm_d;
            tick_q         <= tick_d;
            state_q        <= state_d;
            issue_idx_q    <= issue_idx_d;
            rd_vld_q       <= rd_vld_d;
            rd_idx_q       <= rd_idx_d;
            wr_vld_q       <= wr_vld_d;
            wr_idx_q       <= wr_idx_d;
            wr_duty_q      <= wr_duty_d;
        end
    end

    assign pwm_out     = pwm_q;
    assign period_tick = tick_q;

endmodule

// File: tb/tb_sine_pwm_dds.sv
// Bench for sine_pwm_dds: per-cycle reference model plus table-driven and
// directed period measurements, followed by randomized traffic.
module tb_sine_pwm_dds;

    localparam int unsigned CH  = 3;
    localparam int unsigned PER = 1000;
    localparam int unsigned PW  = 24;
    localparam int unsigned AW  = 8;
    localparam int unsigned DW  = 12;
    localparam real TWO_PI = 6.283185307179586;

    typedef struct {
        logic [CH*PW-1:0] offs;
        int               d0;
        int               d1;
        int               d2;
    } vec_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    logic                sync;
    logic [PW-1:0]       tune_word;
    logic [CH*PW-1:0]    phase_offset;
    logic [CH-1:0]       pwm_out;
    logic                period_tick;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    int hi [CH];
    int lut_tab [1<<AW];

    // Reference model state, in the spec's own terms.
    int            m_cnt = 0;
    logic [PW-1:0] m_acc = '0;
    bit            m_sync_pend = 1'b0;
    int            m_active [CH];
    int            m_shadow [CH];
    logic [CH-1:0] m_pwm = '0;
    logic          m_tick = 1'b0;

    sine_pwm_dds #(
        .CHANNELS (CH),
        .PERIOD   (PER),
        .PHASE_W  (PW),
        .LUT_AW   (AW),
        .LUT_DW   (DW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .tune_word    (tune_word),
        .phase_offset (phase_offset),
        .sync         (sync),
        .pwm_out      (pwm_out),
        .period_tick  (period_tick)
    );

    always #5 clk = ~clk;

    function automatic int duty_of_idx(input int idx);
        return (lut_tab[idx] * PER) >> DW;
    endfunction

    function automatic int duty_of_phase(input logic [PW-1:0] ph);
        return duty_of_idx(int'(ph >> (PW - AW)));
    endfunction

    always @(posedge clk) begin : model
        bit            tk;
        logic [PW-1:0] off;
        if (rst) begin
            m_cnt = 0;
            m_acc = '0;
            m_sync_pend = 1'b0;
            m_pwm = '0;
            m_tick = 1'b0;
            for (int k = 0; k < CH; k++) begin
                m_active[k] = 0;
                m_shadow[k] = 0;
            end
        end else begin
            tk = en && (m_cnt == PER - 1);
            for (int k = 0; k < CH; k++) m_pwm[k] = en && (m_cnt < m_active[k]);
            m_tick = tk;
            if (tk) begin
                m_active = m_shadow;
                m_acc = (m_sync_pend || sync) ? '0 : m_acc + tune_word;
                m_sync_pend = 1'b0;
                for (int k = 0; k < CH; k++) begin
                    off = phase_offset[k*PW +: PW];
                    m_shadow[k] = duty_of_phase(m_acc + off);
                end
            end else if (sync) begin
                m_sync_pend = 1'b1;
            end
            m_cnt = (!en || tk) ? 0 : m_cnt + 1;
        end
    end

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s at %0t: got %0d, want %0d", name, $time, got, want);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (chk_en) begin
            check("pwm_track", int'(pwm_out), int'(m_pwm));
            check("tick_track", int'(period_tick), int'(m_tick));
        end
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        while (period_tick !== 1'b1 && n < 2 * PER + 10) begin
            step();
            n++;
        end
        if (period_tick !== 1'b1) check("tick_timeout", 0, 1);
    endtask

    task automatic goto_mid();
        wait_tick();
        repeat (PER / 2) step();
    endtask

    // Counts highs over the 1000 cycles that start at a period_tick cycle.
    task automatic measure(input bit act);
        wait_tick();
        for (int k = 0; k < CH; k++) hi[k] = 0;
        for (int i = 0; i < PER; i++) begin
            for (int k = 0; k < CH; k++) if (pwm_out[k]) hi[k]++;
            if (act && i == 300) tune_word = 24'h123456;
            if (act && i == 600) sync = 1'b1;
            if (act && i == 601) sync = 1'b0;
            step();
        end
    endtask

    task automatic pulse_sync();
        sync = 1'b1;
        step();
        sync = 1'b0;
    endtask

    initial begin
        vec_t vecs [4];
        int   exp_wrap [5];
        int   n;
        int   h0;
        int   r;

        for (int i = 0; i < (1 << AW); i++) begin
            lut_tab[i] = $rtoi($floor(real'((1 << DW) - 1) *
                         (1.0 + $sin(TWO_PI * real'(i) / real'(1 << AW))) / 2.0 + 0.5));
        end
        vecs[0] = '{offs: {24'h000000, 24'h000000, 24'h000000}, d0: 500, d1: 500, d2: 500};
        vecs[1] = '{offs: {24'hC00000, 24'h400000, 24'h000000}, d0: 500, d1: 999, d2: 0};
        vecs[2] = '{offs: {24'hA00000, 24'h600000, 24'h200000}, d0: 853, d1: 853, d2: 146};
        vecs[3] = '{offs: {24'h000000, 24'hE00000, 24'h800000}, d0: 500, d1: 146, d2: 500};
        exp_wrap = '{500, 999, 500, 0, 500};

        rst = 1'b1;
        en = 1'b1;
        sync = 1'b0;
        tune_word = '0;
        phase_offset = '0;

        for (int i = 0; i < 3; i++) begin
            step();
            chk_en = 1'b1;
            check("rst_pwm", int'(pwm_out), 0);
            check("rst_tick", int'(period_tick), 0);
        end
        rst = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (period_tick !== 1'b1 && n < 1100);
        check("first_tick_latency", n, 1000);

        for (int v = 0; v < 4; v++) begin
            goto_mid();
            tune_word = '0;
            phase_offset = vecs[v].offs;
            pulse_sync();
            measure(1'b0);
            measure(1'b0);
            check($sformatf("vec%0d_ch0", v), hi[0], vecs[v].d0);
            check($sformatf("vec%0d_ch1", v), hi[1], vecs[v].d1);
            check($sformatf("vec%0d_ch2", v), hi[2], vecs[v].d2);
        end

        goto_mid();
        tune_word = 24'h040000;
        phase_offset = '0;
        pulse_sync();
        measure(1'b0);
        for (int i = 0; i < 4; i++) begin
            measure(1'b0);
            check($sformatf("dds_step%0d", i), hi[0], duty_of_idx(4 * i));
        end
        measure(1'b1);
        check("mid_change_hold", hi[0], duty_of_idx(16));
        measure(1'b0);
        check("pre_sync_period", hi[0], duty_of_idx(20));
        measure(1'b0);
        check("sync_zero", hi[0], 500);
        measure(1'b0);
        check("new_tune", hi[0], duty_of_idx(8'h12));

        goto_mid();
        tune_word = 24'h400000;
        pulse_sync();
        measure(1'b0);
        for (int i = 0; i < 5; i++) begin
            measure(1'b0);
            check($sformatf("wrap%0d", i), hi[0], exp_wrap[i]);
        end

        wait_tick();
        for (int i = 0; i < 450; i++) begin
            if (i == 300) begin
                tune_word = '0;
                phase_offset = {24'h000000, 24'h000000, 24'h400000};
            end
            step();
        end
        check("pre_rst_high", int'(pwm_out[0]), 1);
        rst = 1'b1;
        step();
        check("rst_mid_pwm", int'(pwm_out), 0);
        check("rst_mid_tick", int'(period_tick), 0);
        rst = 1'b0;
        measure(1'b0);
        check("post_rst_zero", hi[0], 0);
        measure(1'b0);
        check("post_rst_acc0", hi[0], 999);

        repeat (450) step();
        check("pre_en_high", int'(pwm_out[0]), 1);
        en = 1'b0;
        step();
        check("en_off_pwm", int'(pwm_out), 0);
        repeat (19) step();
        check("en_off_tick", int'(period_tick), 0);
        en = 1'b1;
        n = 0;
        h0 = 0;
        do begin
            step();
            n++;
            if (pwm_out[0]) h0++;
        end while (period_tick !== 1'b1 && n < 1100);
        check("en_restart_tick", n, 1000);
        check("en_held_duty", h0, 999);

        for (int p = 0; p < 20; p++) begin
            wait_tick();
            r = $urandom_range(0, 9);
            for (int i = 0; i < PER - 1; i++) begin
                if (i == 400 && r == 0) begin
                    en = 1'b0;
                    repeat ($urandom_range(1, 30)) step();
                    en = 1'b1;
                    break;
                end
                if (i == 400 && r == 1) begin
                    rst = 1'b1;
                    step();
                    step();
                    rst = 1'b0;
                    break;
                end
                if (i == 500) begin
                    tune_word = PW'($urandom);
                    phase_offset = {PW'($urandom), PW'($urandom), PW'($urandom)};
                end
                if (i == 700) sync = ($urandom_range(0, 2) == 0);
                if (i == 701) sync = 1'b0;
                step();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
